// File: rtl/rgb2hsv_seq_if.sv
// Pixel-in / HSV-out handshake bundle for rgb2hsv_seq.
// slave is the converter's view, master is the producer/consumer side.
interface rgb2hsv_seq_if #(
    parameter int CW   = 5,
    parameter int IN_W = 16
);
    logic            in_valid;
    logic            in_ready;
    logic [IN_W-1:0] data;
    logic            out_valid;
    logic            out_ready;
    logic [8:0]      hue;
    logic [CW-1:0]   saturation;
    logic [CW-1:0]   value;
    logic            hue_invalid;
    logic            busy;

    modport slave (
        input  in_valid, data, out_ready,
        output in_ready, out_valid, hue, saturation, value, hue_invalid, busy
    );

    modport master (
        output in_valid, data, out_ready,
        input  in_ready, out_valid, hue, saturation, value, hue_invalid, busy
    );
endinterface

// File: rtl/rgb2hsv_seq.sv
// Sequential RGB->HSV converter: one pixel at a time, hue via a bit-serial
// restoring divider, optional normalised saturation via a second division pass.
module rgb2hsv_seq #(
    parameter int CW       = 5,
    parameter int IN_W     = 16,
    parameter int SAT_NORM = 1
) (
    input logic          clk,
    input logic          res,
    rgb2hsv_seq_if.slave io
);
    localparam int DW   = (2*CW > CW+6) ? 2*CW : CW+6;
    localparam int QW   = (CW > 6) ? CW : 6;
    localparam int CNTW = $clog2(DW+1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SORT = 3'd1;
    localparam logic [2:0] S_HDIV = 3'd2;
    localparam logic [2:0] S_SDIV = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;
    localparam logic [2:0] S_OUT  = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [CW-1:0]   r_q, r_d, g_q, g_d, b_q, b_d;
    logic [CW-1:0]   max_q, max_d, chr_q, chr_d, div_q, div_d, rem_q, rem_d;
    logic            neg_q, neg_d, inv_q, inv_d;
    logic [8:0]      base_q, base_d;
    logic [DW-1:0]   dvd_q, dvd_d;
    logic [QW-1:0]   quo_q, quo_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [5:0]      hq_q, hq_d;
    logic [8:0]      hue_q, hue_d;
    logic [CW-1:0]   sat_q, sat_d, val_q, val_d;
    logic            hinv_q, hinv_d;

    logic unused_data;
    assign unused_data = ^io.data;

    // Sort stage: max/min with R > G > B tie priority, signed hue numerator.
    logic [CW-1:0]   mx, mn, anum;
    logic [CW:0]     num, anum_w;
    logic [8:0]      base;
    logic [CW+5:0]   num60;
    logic [2*CW-1:0] dsat;

    always_comb begin
        mx   = b_q;
        num  = {1'b0, r_q} - {1'b0, g_q};
        base = 9'd240;
        if (r_q >= g_q && r_q >= b_q) begin
            mx   = r_q;
            num  = {1'b0, g_q} - {1'b0, b_q};
            base = 9'd0;
        end else if (g_q >= b_q) begin
            mx   = g_q;
            num  = {1'b0, b_q} - {1'b0, r_q};
            base = 9'd120;
        end
        if (r_q <= g_q && r_q <= b_q) mn = r_q;
        else if (g_q <= b_q)          mn = g_q;
        else                          mn = b_q;
        anum_w = num[CW] ? (~num + 1'b1) : num;
        anum   = anum_w[CW-1:0];
        num60  = {anum, 6'd0} - {4'd0, anum, 2'd0};
        dsat   = {chr_q, {CW{1'b0}}} - {{CW{1'b0}}, chr_q};
    end

    // One restoring-division step per cycle.
    logic [CW:0]   trial, diff;
    logic          qbit;
    logic [CW-1:0] rem_nx;
    logic [QW-1:0] quo_nx;

    always_comb begin
        trial  = {rem_q, dvd_q[DW-1]};
        diff   = trial - {1'b0, div_q};
        qbit   = (trial >= {1'b0, div_q});
        rem_nx = qbit ? diff[CW-1:0] : trial[CW-1:0];
        quo_nx = (quo_q << 1) | QW'(qbit);
    end

    logic [8:0] h;

    always_comb begin
        state_d = state_q;
        r_d = r_q;  g_d = g_q;  b_d = b_q;
        max_d = max_q;  chr_d = chr_q;  div_d = div_q;  rem_d = rem_q;
        neg_d = neg_q;  inv_d = inv_q;  base_d = base_q;
        dvd_d = dvd_q;  quo_d = quo_q;  cnt_d = cnt_q;  hq_d = hq_q;
        hue_d = hue_q;  sat_d = sat_q;  val_d = val_q;  hinv_d = hinv_q;
        h = base_q + {3'd0, hq_q};
        if (neg_q)
            h = ({3'd0, hq_q} > base_q) ? (9'd360 - {3'd0, hq_q}) : (base_q - {3'd0, hq_q});

        case (state_q)
            S_IDLE: if (io.in_valid) begin
                r_d = io.data[3*CW-1:2*CW];
                g_d = io.data[2*CW-1:CW];
                b_d = io.data[CW-1:0];
                state_d = S_SORT;
            end
            S_SORT: begin
                max_d  = mx;
                chr_d  = mx - mn;
                neg_d  = num[CW];
                base_d = base;
                hq_d   = 6'd0;
                inv_d  = (mx == mn);
                rem_d  = '0;
                quo_d  = '0;
                div_d  = mx - mn;
                dvd_d  = DW'(num60) << (DW - (CW+6));
                cnt_d  = CNTW'(CW+6);
                state_d = (mx == mn) ? S_FIN : S_HDIV;
            end
            S_HDIV, S_SDIV: begin
                rem_d = rem_nx;
                dvd_d = dvd_q << 1;
                quo_d = quo_nx;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNTW'(1)) begin
                    state_d = S_FIN;
                    if (state_q == S_HDIV) begin
                        hq_d = quo_nx[5:0];
                        if (SAT_NORM != 0) begin
                            rem_d = '0;
                            quo_d = '0;
                            div_d = max_q;
                            dvd_d = DW'(dsat) << (DW - 2*CW);
                            cnt_d = CNTW'(2*CW);
                            state_d = S_SDIV;
                        end
                    end
                end
            end
            S_FIN: begin
                hue_d  = inv_q ? 9'd0 : h;
                sat_d  = inv_q ? '0 : ((SAT_NORM != 0) ? quo_q[CW-1:0] : chr_q);
                val_d  = max_q;
                hinv_d = inv_q;
                state_d = S_OUT;
            end
            S_OUT: if (io.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= S_IDLE;
            r_q <= '0;  g_q <= '0;  b_q <= '0;
            max_q <= '0;  chr_q <= '0;  div_q <= '0;  rem_q <= '0;
            neg_q <= 1'b0;  inv_q <= 1'b0;  base_q <= '0;
            dvd_q <= '0;  quo_q <= '0;  cnt_q <= '0;  hq_q <= '0;
            hue_q <= '0;  sat_q <= '0;  val_q <= '0;  hinv_q <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q <= r_d;  g_q <= g_d;  b_q <= b_d;
            max_q <= max_d;  chr_q <= chr_d;  div_q <= div_d;  rem_q <= rem_d;
            neg_q <= neg_d;  inv_q <= inv_d;  base_q <= base_d;
            dvd_q <= dvd_d;  quo_q <= quo_d;  cnt_q <= cnt_d;  hq_q <= hq_d;
            hue_q <= hue_d;  sat_q <= sat_d;  val_q <= val_d;  hinv_q <= hinv_d;
        end
    end

    assign io.in_ready    = (state_q == S_IDLE);
    assign io.out_valid   = (state_q == S_OUT);
    assign io.busy        = (state_q != S_IDLE);
    assign io.hue         = hue_q;
    assign io.saturation  = sat_q;
    assign io.value       = val_q;
    assign io.hue_invalid = hinv_q;
endmodule

// File: tb/tb_rgb2hsv_seq.sv
// Bench for rgb2hsv_seq: three configurations (CW5 norm, CW5 chroma, CW8 norm)
// behind one selectable driver, vector table plus random pixels vs. a model.
module tb_rgb2hsv_seq;
    logic clk = 1'b0;
    logic res = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  sel  = 2'd0;
    logic        iv   = 1'b0;
    logic [23:0] din  = '0;
    logic        ordy = 1'b1;

    rgb2hsv_seq_if #(.CW(5), .IN_W(16)) ifa ();
    rgb2hsv_seq_if #(.CW(5), .IN_W(16)) ifb ();
    rgb2hsv_seq_if #(.CW(8), .IN_W(24)) ifc ();

    assign ifa.in_valid = iv && (sel == 2'd0);
    assign ifb.in_valid = iv && (sel == 2'd1);
    assign ifc.in_valid = iv && (sel == 2'd2);
    assign ifa.data = din[15:0];
    assign ifb.data = din[15:0];
    assign ifc.data = din;
    assign ifa.out_ready = ordy;
    assign ifb.out_ready = ordy;
    assign ifc.out_ready = ordy;

    rgb2hsv_seq #(.CW(5), .IN_W(16), .SAT_NORM(1)) dut_a (.clk(clk), .res(res), .io(ifa));
    rgb2hsv_seq #(.CW(5), .IN_W(16), .SAT_NORM(0)) dut_b (.clk(clk), .res(res), .io(ifb));
    rgb2hsv_seq #(.CW(8), .IN_W(24), .SAT_NORM(1)) dut_c (.clk(clk), .res(res), .io(ifc));

    logic       o_valid, o_rdy, o_inv, o_busy;
    logic [8:0] o_hue;
    logic [7:0] o_sat, o_val;

    always_comb begin
        o_valid = ifa.out_valid;  o_rdy = ifa.in_ready;  o_inv = ifa.hue_invalid;
        o_busy  = ifa.busy;       o_hue = ifa.hue;
        o_sat   = {3'd0, ifa.saturation};  o_val = {3'd0, ifa.value};
        if (sel == 2'd1) begin
            o_valid = ifb.out_valid;  o_rdy = ifb.in_ready;  o_inv = ifb.hue_invalid;
            o_busy  = ifb.busy;       o_hue = ifb.hue;
            o_sat   = {3'd0, ifb.saturation};  o_val = {3'd0, ifb.value};
        end else if (sel == 2'd2) begin
            o_valid = ifc.out_valid;  o_rdy = ifc.in_ready;  o_inv = ifc.hue_invalid;
            o_busy  = ifc.busy;       o_hue = ifc.hue;
            o_sat   = ifc.saturation; o_val = ifc.value;
        end
    end

    int nerr = 0;
    int nchk = 0;

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: HSV straight from the definition with integer arithmetic.
    function automatic void ref_px(input int r, g, b, cw, sn,
                                   output int hue, sat, val, inv, lat);
        int mx, mn, d, num, base, q;
        if (r >= g && r >= b)  begin mx = r; num = g - b; base = 0;   end
        else if (g >= b)       begin mx = g; num = b - r; base = 120; end
        else                   begin mx = b; num = r - g; base = 240; end
        mn  = (r < g) ? ((r < b) ? r : b) : ((g < b) ? g : b);
        d   = mx - mn;
        val = mx;
        if (d == 0) begin
            hue = 0; sat = 0; inv = 1; lat = 2;
        end else begin
            q   = ((num < 0) ? -num : num) * 60 / d;
            hue = base + ((num < 0) ? -q : q);
            if (hue < 0) hue += 360;
            sat = sn ? (d * ((1 << cw) - 1) / mx) : d;
            inv = 0;
            lat = sn ? 3*cw + 8 : cw + 8;
        end
    endfunction

    function automatic logic [23:0] pack(input int r, g, b, cw);
        return 24'(($urandom() << (3*cw)) | (r << (2*cw)) | (g << cw) | b);
    endfunction

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!o_valid && lat < 100);
    endtask

    task automatic run_px(input int r, g, b, cw, eh, es, ev, ei, el, input string tag);
        int lat;
        @(negedge clk);
        for (int k = 0; k < 100 && !o_rdy; k++) @(negedge clk);
        chk({tag, "_in_ready"}, o_rdy, 1);
        din = pack(r, g, b, cw);
        iv  = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        chk({tag, "_busy"}, o_busy, 1);
        wait_result(lat);
        chk({tag, "_latency"}, lat, el);
        chk({tag, "_hue"}, o_hue, eh);
        chk({tag, "_sat"}, o_sat, es);
        chk({tag, "_val"}, o_val, ev);
        chk({tag, "_hinv"}, o_inv, ei);
    endtask

    typedef struct {
        int sel, r, g, b, hue, sat, val, inv, lat;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int eh, es, ev, ei, el, lat, seen, r, g, b;

        tbl[0] = '{0, 31,  0,  0,   0,  31,  31, 0, 23};
        tbl[1] = '{0,  0, 31,  0, 120,  31,  31, 0, 23};
        tbl[2] = '{0, 31, 31,  0,  60,  31,  31, 0, 23};
        tbl[3] = '{0,  0, 31, 31, 180,  31,  31, 0, 23};
        tbl[4] = '{0, 31,  0, 31, 300,  31,  31, 0, 23};
        tbl[5] = '{0, 20, 10,  4,  22,  24,  20, 0, 23};
        tbl[6] = '{0,  7,  7,  7,   0,   0,   7, 1,  2};
        tbl[7] = '{0,  0,  0,  0,   0,   0,   0, 1,  2};
        tbl[8] = '{1, 20, 10,  4,  22,  16,  20, 0, 13};
        tbl[9] = '{2, 255, 128, 0, 30, 255, 255, 0, 32};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", o_rdy, 1);
        chk("rst_out_valid", o_valid, 0);
        res = 1'b0;
        @(negedge clk);
        chk("rst_busy", o_busy, 0);
        chk("rst_hue", o_hue, 0);
        chk("rst_val", o_val, 0);
        chk("rst_hinv", o_inv, 0);

        foreach (tbl[i]) begin
            sel = 2'(tbl[i].sel);
            run_px(tbl[i].r, tbl[i].g, tbl[i].b, (tbl[i].sel == 2) ? 8 : 5,
                   tbl[i].hue, tbl[i].sat, tbl[i].val, tbl[i].inv, tbl[i].lat,
                   $sformatf("vec%0d", i));
        end

        // Backpressure: result held, no accept until released
        sel  = 2'd0;
        ordy = 1'b0;
        run_px(20, 10, 4, 5, 22, 24, 20, 0, 23, "bp_first");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            iv  = 1'b1;
            din = pack(31, 0, 0, 5);
            @(posedge clk); #1;
            chk("bp_valid_held", o_valid, 1);
            chk("bp_in_ready", o_rdy, 0);
            chk("bp_hue_held", o_hue, 22);
            chk("bp_sat_held", o_sat, 24);
        end
        @(negedge clk);
        ordy = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", o_valid, 0);
        chk("bp_release_ready", o_rdy, 1);
        @(posedge clk); #1;
        iv = 1'b0;
        chk("bp_next_accepted", o_busy, 1);
        wait_result(lat);
        chk("bp_next_latency", lat, 23);
        chk("bp_next_hue", o_hue, 0);
        chk("bp_next_sat", o_sat, 31);

        // Reset while dividing
        run_px(0, 31, 0, 5, 120, 31, 31, 0, 23, "pre_rst");
        @(negedge clk);
        for (int k = 0; k < 100 && !o_rdy; k++) @(negedge clk);
        din = pack(20, 10, 4, 5);
        iv  = 1'b1;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        chk("hdiv_hue_before_rst", o_hue, 120);
        res = 1'b1;
        #1;
        chk("hdiv_rst_in_ready", o_rdy, 1);
        chk("hdiv_rst_valid", o_valid, 0);
        chk("hdiv_rst_busy", o_busy, 0);
        chk("hdiv_rst_hue", o_hue, 0);
        chk("hdiv_rst_val", o_val, 0);
        #2;
        res  = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (o_valid) seen = 1;
        end
        chk("hdiv_rst_no_output", seen, 0);

        // Random pixels against the model on all three configurations
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            for (int i = 0; i < ((s == 0) ? 25 : 10); i++) begin
                r = $urandom_range(0, (s == 2) ? 255 : 31);
                g = $urandom_range(0, (s == 2) ? 255 : 31);
                b = $urandom_range(0, (s == 2) ? 255 : 31);
                if (i % 6 == 1) g = r;
                if (i % 6 == 3) b = g;
                ref_px(r, g, b, (s == 2) ? 8 : 5, (s == 1) ? 0 : 1, eh, es, ev, ei, el);
                run_px(r, g, b, (s == 2) ? 8 : 5, eh, es, ev, ei, el,
                       $sformatf("rnd%0d_%0d", s, i));
            end
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
